// File: rtl/midi_event_ring_writer.sv
// Frames MIDI channel-voice messages, timestamps them and writes packed words into a RAM ring buffer.
// Optional feature: define MIDI_RUNNING_STATUS_EN to keep the status byte across messages (running status).
module midi_event_ring_writer #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h800,
    parameter int                PTR_W     = 8,
    parameter int                TICK_DIV  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic              irq,
    output logic [15:0]       overflow_cnt,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, WRITE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         status_q, status_d;
    logic [7:0]         data1_q, data1_d;
    logic [7:0]         data2_q, data2_d;
    logic [7:0]         ts_msg_q, ts_msg_d;
    logic [7:0]         ts_q, ts_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [15:0]        ovf_q, ovf_d;
    logic               irq_q, irq_d;
    logic               rs_q, rs_d;
    logic               accept;
    logic               full;
    logic               one_byte;
    logic               do_write;

    assign in_ready = !(enable && state_q == WRITE);
    assign accept   = in_valid && in_ready;
    assign full     = (wr_ptr_q + PTR_W'(1)) == rd_ptr;
    assign one_byte = status_q[7:5] == 3'b110;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        ts_msg_d = ts_msg_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        rs_d     = rs_q;
        do_write = 1'b0;

        if (tick_q == TICK_LAST) begin
            tick_d = '0;
            ts_d   = ts_q + 8'd1;
        end else begin
            tick_d = tick_q + TICK_W'(1);
            ts_d   = ts_q;
        end

        if (!enable) begin
            state_d = IDLE;
            rs_d    = 1'b0;
        end else if (state_q == WRITE) begin
            if (!full) begin
                do_write = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else if (ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
`ifdef MIDI_RUNNING_STATUS_EN
            // rs marks that the next data1 begins a new message, so it takes a fresh timestamp
            state_d = WAIT_D1;
            rs_d    = 1'b1;
`else
            state_d  = IDLE;
            status_d = 8'h00;
`endif
        end else if (accept) begin
            if (in_data[7:3] == 5'b11111) begin
                state_d = state_q;
            end else if (in_data[7:4] == 4'hF) begin
                status_d = 8'h00;
                state_d  = IDLE;
                rs_d     = 1'b0;
            end else if (in_data[7]) begin
                status_d = in_data;
                ts_msg_d = ts_q;
                state_d  = WAIT_D1;
                rs_d     = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
`ifdef MIDI_RUNNING_STATUS_EN
                        if (status_q != 8'h00) begin
                            data1_d  = in_data;
                            ts_msg_d = ts_q;
                            if (one_byte) begin
                                data2_d = 8'h00;
                                state_d = WRITE;
                            end else begin
                                state_d = WAIT_D2;
                            end
                        end
`endif
                    end
                    WAIT_D1: begin
                        data1_d = in_data;
                        rs_d    = 1'b0;
                        if (rs_q) begin
                            ts_msg_d = ts_q;
                        end
                        if (one_byte) begin
                            data2_d = 8'h00;
                            state_d = WRITE;
                        end else begin
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        data2_d = in_data;
                        state_d = WRITE;
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        irq_d = wr_ptr_d != rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            status_q <= 8'h00;
            data1_q  <= 8'h00;
            data2_q  <= 8'h00;
            ts_msg_q <= 8'h00;
            ts_q     <= 8'h00;
            tick_q   <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 16'h0000;
            irq_q    <= 1'b0;
            rs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            ts_msg_q <= ts_msg_d;
            ts_q     <= ts_d;
            tick_q   <= tick_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            rs_q     <= rs_d;
        end
    end

    assign wr_ptr         = wr_ptr_q;
    assign irq            = irq_q;
    assign overflow_cnt   = ovf_q;
    assign avm_address    = BASE_ADDR + ADDR_W'(wr_ptr_q);
    assign avm_byteenable = 4'hF;
    assign avm_chipselect = do_write;
    assign avm_write      = do_write;
    assign avm_writedata  = do_write ? {status_q, data1_q, data2_q, ts_msg_q} : 32'h0;
    assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_midi_event_ring_writer.sv
// Self-checking bench for midi_event_ring_writer: directed vector table, corner sequences
// and a randomized byte stream checked against a message-level reference model.
module tb_midi_event_ring_writer;

    localparam int          ADDR_W   = 12;
    localparam logic [11:0] BASE     = 12'h800;
    localparam int          PTR_W    = 8;
    localparam int          TICK_DIV = 4;
    localparam int          DEPTH    = 1 << PTR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PTR_W-1:0]  rd_ptr = '0;
    logic [PTR_W-1:0]  wr_ptr;
    logic              irq;
    logic [15:0]       overflow_cnt;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_clken;

    midi_event_ring_writer #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .PTR_W(PTR_W), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .irq(irq),
        .overflow_cnt(overflow_cnt), .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_clken(avm_clken)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // cycle count since the last reset edge; the timestamp is this divided by TICK_DIV
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    logic [43:0] obs_q[$];
    logic [43:0] exp_q[$];
    logic [43:0] last_obs = '0;
    int          obs_total = 0;

    always @(negedge clk) begin
        if (avm_chipselect && avm_write) begin
            obs_q.push_back({avm_address, avm_writedata});
            last_obs  = {avm_address, avm_writedata};
            obs_total = obs_total + 1;
        end
    end

    // reference model state: message phase 0=no message, 1=want data1, 2=want data2
    int         m_phase = 0;
    logic [7:0] m_status = 8'h00;
    logic [7:0] m_d1 = 8'h00;
    logic [7:0] m_ts = 8'h00;
    bit         m_rs = 1'b0;
    int         m_wp = 0;
    int         m_ovf = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic modelEmit(input logic [7:0] d2);
        logic [31:0] word;
        word = {m_status, m_d1, d2, m_ts};
        if (((m_wp + 1) % DEPTH) == int'(rd_ptr)) begin
            if (m_ovf < 65535) m_ovf++;
        end else begin
            exp_q.push_back({12'(int'(BASE) + m_wp), word});
            m_wp = (m_wp + 1) % DEPTH;
        end
`ifdef MIDI_RUNNING_STATUS_EN
        m_phase = 1;
        m_rs    = 1'b1;
`else
        m_phase  = 0;
        m_status = 8'h00;
`endif
    endtask

    task automatic takeData1(input logic [7:0] b);
        m_d1 = b;
        if (m_status >= 8'hC0 && m_status <= 8'hDF) modelEmit(8'h00);
        else m_phase = 2;
    endtask

    task automatic modelByte(input logic [7:0] b);
        logic [7:0] ts_now;
        ts_now = 8'((cyc / TICK_DIV) % 256);
        if (!enable || b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_status = 8'h00; m_phase = 0; m_rs = 1'b0;
        end else if (b >= 8'h80) begin
            m_status = b; m_ts = ts_now; m_phase = 1; m_rs = 1'b0;
        end else if (m_phase == 1) begin
            if (m_rs) m_ts = ts_now;
            m_rs = 1'b0;
            takeData1(b);
        end else if (m_phase == 2) begin
            modelEmit(b);
        end else begin
`ifdef MIDI_RUNNING_STATUS_EN
            if (m_status != 8'h00) begin
                m_ts = ts_now;
                takeData1(b);
            end
`endif
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int waitc;
        waitc    = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("[TB] FAIL in_ready timeout: got 0, expected 1 within 8 cycles");
            in_valid = 1'b0;
            return;
        end
        modelByte(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        m_phase = 0; m_status = 8'h00; m_rs = 1'b0; m_wp = 0; m_ovf = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic checkWrites(input string tag);
        logic [43:0] e;
        logic [43:0] o;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checkOutput({tag, " addr"}, 64'(o[43:32]), 64'(e[43:32]));
            checkOutput({tag, " data"}, 64'(o[31:0]), 64'(e[31:0]));
        end
        checkOutput({tag, " missing writes"}, 64'(exp_q.size()), 64'd0);
        checkOutput({tag, " extra writes"}, 64'(obs_q.size()), 64'd0);
        exp_q.delete();
        obs_q.delete();
        checkOutput({tag, " wr_ptr"}, 64'(wr_ptr), 64'(m_wp));
        checkOutput({tag, " overflow_cnt"}, 64'(overflow_cnt), 64'(m_ovf));
        checkOutput({tag, " irq"}, 64'(irq), 64'(m_wp != int'(rd_ptr)));
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [31:0] bytes;
        int          exp_n;
        logic [23:0] exp_hi;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base_n;
        int span;

        vecs[0] = '{"note_on",      3, 32'h903C6400, 1, 24'h903C64};
        vecs[1] = '{"prog_change",  2, 32'hC5070000, 1, 24'hC50700};
        vecs[2] = '{"realtime_mid", 4, 32'h903CF864, 1, 24'h903C64};
        vecs[3] = '{"sysex_drop",   3, 32'hF03C6400, 0, 24'h0};
        vecs[4] = '{"common_abort", 4, 32'h903CF264, 0, 24'h0};
        vecs[5] = '{"status_abort", 4, 32'h80903C64, 1, 24'h903C64};
        vecs[6] = '{"chan_press",   2, 32'hD37F0000, 1, 24'hD37F00};
        vecs[7] = '{"orphan_data",  3, 32'hF03C4000, 0, 24'h0};

        doReset();
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset avm_clken", 64'(avm_clken), 64'd1);
        checkOutput("reset byteenable", 64'(avm_byteenable), 64'hF);
        checkOutput("reset avm_address", 64'(avm_address), 64'h800);
        checkOutput("reset avm_write", 64'({avm_write, avm_chipselect}), 64'd0);
        checkOutput("reset writedata", 64'(avm_writedata), 64'd0);
        checkOutput("reset wr_ptr", 64'(wr_ptr), 64'd0);
        checkOutput("reset irq", 64'(irq), 64'd0);
        checkOutput("reset overflow", 64'(overflow_cnt), 64'd0);

        // first note after reset carries timestamp zero
        applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
        settle(3);
        checkOutput("t1 write count", 64'(obs_total), 64'd1);
        checkOutput("t1 word", 64'(last_obs), {20'd0, 12'h800, 32'h903C6400});
        checkOutput("t1 wr_ptr", 64'(wr_ptr), 64'd1);
        checkOutput("t1 irq", 64'(irq), 64'd1);

        // one-data-byte message: strobe the cycle after 07, in_ready low only then
        applyStimulus(8'hC5); applyStimulus(8'h07);
        checkOutput("t2 in_ready in WRITE", 64'(in_ready), 64'd0);
        checkOutput("t2 strobe", 64'({avm_chipselect, avm_write}), 64'd3);
        checkOutput("t2 data hi", 64'(avm_writedata[31:8]), 64'hC50700);
        checkOutput("t2 wr_ptr before update", 64'(wr_ptr), 64'd1);
        @(negedge clk);
        checkOutput("t2 in_ready after WRITE", 64'(in_ready), 64'd1);
        checkOutput("t2 strobe off", 64'({avm_chipselect, avm_write}), 64'd0);
        checkOutput("t2 wr_ptr updated", 64'(wr_ptr), 64'd2);
        settle(1);
        checkWrites("t1t2");

        for (int i = 0; i < 8; i++) begin
            logic [31:0] bs;
            base_n = obs_total;
            bs = vecs[i].bytes;
            for (int k = 0; k < vecs[i].n; k++) applyStimulus(bs[31-8*k -: 8]);
            settle(3);
            checkOutput({vecs[i].name, " count"}, 64'(obs_total - base_n), 64'(vecs[i].exp_n));
            if (vecs[i].exp_n > 0)
                checkOutput({vecs[i].name, " hi"}, 64'(last_obs[31:8]), 64'(vecs[i].exp_hi));
            checkWrites(vecs[i].name);
        end

        // running status
        applyStimulus(8'hF0);
        base_n = obs_total;
        applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
        applyStimulus(8'h3E); applyStimulus(8'h40);
        settle(3);
`ifdef MIDI_RUNNING_STATUS_EN
        checkOutput("t5 count", 64'(obs_total - base_n), 64'd2);
        checkOutput("t5 second hi", 64'(last_obs[31:8]), 64'h903E40);
`else
        checkOutput("t5 count", 64'(obs_total - base_n), 64'd1);
        checkOutput("t5 only hi", 64'(last_obs[31:8]), 64'h903C64);
`endif
        checkWrites("t5");

        // reset mid-frame discards the partial message
        applyStimulus(8'h90); applyStimulus(8'h3C);
        doReset();
        base_n = obs_total;
        applyStimulus(8'h80); applyStimulus(8'h3C); applyStimulus(8'h00);
        settle(3);
        checkOutput("t6 count", 64'(obs_total - base_n), 64'd1);
        checkOutput("t6 word", 64'(last_obs), {20'd0, 12'h800, 32'h803C0000});
        checkWrites("t6");

        // fill the ring: one slot stays empty, the 256th note overflows
        doReset();
        rd_ptr = '0;
        base_n = obs_total;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'h90);
            applyStimulus(8'($urandom_range(0, 127)));
            applyStimulus(8'($urandom_range(0, 127)));
        end
        settle(3);
        checkOutput("t4 count", 64'(obs_total - base_n), 64'd255);
        checkOutput("t4 last addr", 64'(last_obs[43:32]), 64'h8FE);
        checkOutput("t4 overflow", 64'(overflow_cnt), 64'd1);
        checkOutput("t4 wr_ptr", 64'(wr_ptr), 64'd255);
        rd_ptr = 8'd10;
        applyStimulus(8'h95); applyStimulus(8'h40); applyStimulus(8'h7F);
        settle(3);
        checkOutput("t4 wrap addr", 64'(last_obs[43:32]), 64'h8FF);
        checkOutput("t4 wrap wr_ptr", 64'(wr_ptr), 64'd0);
        checkOutput("t4 wrap irq", 64'(irq), 64'd1);
        checkWrites("t4");

        // randomized stream with enable toggles and CPU draining
        doReset();
        rd_ptr = '0;
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                settle(1);
                enable = ~enable;
                if (!enable) begin
                    m_phase = 0;
                    m_rs    = 1'b0;
                end
            end else if (r < 12) begin
                settle(1);
                span   = (m_wp - int'(rd_ptr) + DEPTH) % DEPTH;
                rd_ptr = PTR_W'((int'(rd_ptr) + $urandom_range(0, span)) % DEPTH);
            end
            r = $urandom_range(0, 99);
            if (r < 10)      b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 14) b = 8'($urandom_range(8'hF0, 8'hF7));
            else if (r < 40) b = 8'($urandom_range(8'h80, 8'hEF));
            else             b = 8'($urandom_range(8'h00, 8'h7F));
            applyStimulus(b);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        settle(1);
        enable = 1'b1;
        settle(3);
        checkWrites("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
